// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// requester port indices and helpers that locate the data region.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        RDWAIT = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } arb_state_t;

    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    localparam int DMEM_DEPTH_DEF = 2048;

    // First word index of the data region (upper half of the memory).
    function automatic int data_base_word(input int depth);
        return depth / 2;
    endfunction

    // One past the last word index of the data region.
    function automatic int data_limit_word(input int depth);
        return depth;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the mem_data port. The arbiter
// uses the slave view; the requesters and memory sit on the master view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  done0;
    logic                  err0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  done1;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output gnt0, done0, err0, rdata0,
        output gnt1, done1, err1, rdata1,
        output mem_rd_en, mem_wr_en, mem_addr, mem_din
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  gnt0, done0, err0, rdata0,
        input  gnt1, done1, err1, rdata1,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// pointer register. The pointer names the port that wins a tie and only
// moves when both ports contend, so a lone requester never disturbs it.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    // One-hot pick; on a tie the favoured port wins and favour passes over.
    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (en) begin
            if (&req) begin
                gnt[ptr] = 1'b1;
                ptr_next = ~ptr;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single mem_data port between the core LSU (port 0) and the
// debug/DMA loader (port 1). Every output is a flop; each transaction is
// decided in IDLE and then walks ISSUE -> (RDWAIT) -> RESP, or goes straight
// to ERR when the address falls outside the aligned data region.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = DMEM_DEPTH_DEF
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] BASE_W  = WORD_W'(data_base_word(MEM_DEPTH));
    localparam logic [WORD_W-1:0] LIMIT_W = WORD_W'(data_limit_word(MEM_DEPTH));

    arb_state_t            state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic                  we_reg, we_next;
    logic                  ptr_reg, ptr_next;
    logic [1:0]            gnt_reg, gnt_next;
    logic [1:0]            done_reg, done_next;
    logic [1:0]            err_reg, err_next;
    logic [DATA_WIDTH-1:0] rdata_reg [2];
    logic [DATA_WIDTH-1:0] rdata_next [2];
    logic                  mem_rd_en_reg, mem_rd_en_next;
    logic                  mem_wr_en_reg, mem_wr_en_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_din_reg, mem_din_next;

    logic [1:0]            req_vec;
    logic [1:0]            pick;
    logic                  ptr_upd;
    logic                  win_port;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_legal;

    assign req_vec   = {bus.req1, bus.req0};
    assign win_port  = pick[PORT_DBG];
    assign win_we    = win_port ? bus.we1    : bus.we0;
    assign win_addr  = win_port ? bus.addr1  : bus.addr0;
    assign win_wdata = win_port ? bus.wdata1 : bus.wdata0;

    // Word-aligned and inside the upper half; the whole upper address is
    // compared so high garbage bits cannot alias into the data region.
    assign win_legal = (win_addr[1:0] == 2'b00)
                    && (win_addr[ADDR_WIDTH-1:2] >= BASE_W)
                    && (win_addr[ADDR_WIDTH-1:2] <  LIMIT_W);

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .ptr      (ptr_reg),
        .en       (state_reg == IDLE),
        .gnt      (pick),
        .ptr_next (ptr_upd)
    );

    // Next state and next registered outputs; pulses default low each cycle.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        we_next        = we_reg;
        ptr_next       = ptr_upd;
        gnt_next       = 2'b00;
        done_next      = 2'b00;
        err_next       = 2'b00;
        mem_rd_en_next = 1'b0;
        mem_wr_en_next = 1'b0;
        mem_addr_next  = '0;
        mem_din_next   = '0;
        for (int i = 0; i < 2; i++) begin
            rdata_next[i] = rdata_reg[i];
        end

        case (state_reg)
            IDLE: begin
                if (|pick) begin
                    owner_next         = win_port;
                    we_next            = win_we;
                    gnt_next[win_port] = 1'b1;
                    if (win_legal) begin
                        state_next     = ISSUE;
                        mem_wr_en_next = win_we;
                        mem_rd_en_next = ~win_we;
                        mem_addr_next  = win_addr;
                        mem_din_next   = win_wdata;
                    end else begin
                        state_next           = ERR;
                        done_next[win_port]  = 1'b1;
                        err_next[win_port]   = 1'b1;
                        rdata_next[win_port] = '0;
                    end
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next           = RESP;
                    done_next[owner_reg] = 1'b1;
                end else begin
                    state_next = RDWAIT;
                end
            end
            RDWAIT: begin
                state_next            = RESP;
                done_next[owner_reg]  = 1'b1;
                rdata_next[owner_reg] = bus.mem_dout;
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM, arbitration pointer and all control/handshake output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            ptr_reg       <= 1'b0;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            mem_rd_en_reg <= 1'b0;
            mem_wr_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            mem_rd_en_reg <= mem_rd_en_next;
            mem_wr_en_reg <= mem_wr_en_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            // Per-port read data, held until that port's next read or error.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_reg[gi] <= '0;
                end else begin
                    rdata_reg[gi] <= rdata_next[gi];
                end
            end
        end
    endgenerate

    assign bus.gnt0      = gnt_reg[PORT_CORE];
    assign bus.done0     = done_reg[PORT_CORE];
    assign bus.err0      = err_reg[PORT_CORE];
    assign bus.rdata0    = rdata_reg[PORT_CORE];
    assign bus.gnt1      = gnt_reg[PORT_DBG];
    assign bus.done1     = done_reg[PORT_DBG];
    assign bus.err1      = err_reg[PORT_DBG];
    assign bus.rdata1    = rdata_reg[PORT_DBG];
    assign bus.mem_rd_en = mem_rd_en_reg;
    assign bus.mem_wr_en = mem_wr_en_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_din   = mem_din_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. The arbiter is built with a 4096-word
// memory so the data region spans byte addresses 0x2000..0x3FFC. A small
// word memory with one-cycle registered read stands in for mem_data.
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks      = 0;
    int failures    = 0;
    int wr_cycles   = 0;
    int both_cycles = 0;
    int wr_before   = 0;

    logic [31:0] mem [4096];
    bit          written [4096];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_DEPTH  (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Contents of a word that has never been written.
    function automatic logic [31:0] init_word(input logic [11:0] idx);
        return 32'hC0DE_0000 | {20'd0, idx};
    endfunction

    // mem_data model: write on the edge, read data registered one cycle.
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr[13:2]]     <= bus.mem_din;
            written[bus.mem_addr[13:2]] <= 1'b1;
        end
        if (bus.mem_rd_en) begin
            bus.mem_dout <= written[bus.mem_addr[13:2]] ? mem[bus.mem_addr[13:2]]
                                                        : init_word(bus.mem_addr[13:2]);
        end
    end

    // Count memory enable activity between edges.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_wr_en) wr_cycles++;
            if (bus.mem_wr_en && bus.mem_rd_en) both_cycles++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    // {gnt, done, err} of one port.
    function automatic logic [2:0] hs(input int port);
        return (port == 0) ? {bus.gnt0, bus.done0, bus.err0} : {bus.gnt1, bus.done1, bus.err1};
    endfunction

    function automatic logic [31:0] rdata(input int port);
        return (port == 0) ? bus.rdata0 : bus.rdata1;
    endfunction

    // One uncontended transaction, starting with the arbiter in IDLE and
    // ending with it back in IDLE.
    task automatic txn(input string tag, input int port, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata);
        drive(port, 1'b1, we, addr, wdata);
        tick();
        if (exp_err) begin
            check({tag, " err hs"}, hs(port), 3'b111);
            check({tag, " err rdata"}, rdata(port), 32'd0);
            check({tag, " err mem_en"}, {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
            drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
            tick();
        end else begin
            check({tag, " issue hs"}, hs(port), 3'b100);
            check({tag, " issue en"}, {bus.mem_rd_en, bus.mem_wr_en}, {~we, we});
            check({tag, " issue addr"}, bus.mem_addr, addr);
            if (we) check({tag, " issue din"}, bus.mem_din, wdata);
            drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
            tick();
            if (!we) begin
                check({tag, " rdwait hs"}, hs(port), 3'b000);
                tick();
            end
            check({tag, " resp hs"}, hs(port), 3'b010);
            check({tag, " resp mem_en"}, {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
            if (!we) check({tag, " resp rdata"}, rdata(port), exp_rdata);
            tick();
        end
        $display("txn %s port=%0d we=%0d addr=%h done", tag, port, we, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("reset hs", {hs(0), hs(1)}, 6'b000_000);
        check("reset mem", {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr}, 34'd0);
        check("reset rdata", {rdata(0), rdata(1)}, 64'd0);
        reset = 1'b1;
        tick();

        // Reset asserted while a port 0 read waits for data.
        drive(0, 1'b1, 1'b0, 32'h2000, 32'd0);
        tick();
        check("midrd issue", hs(0), 3'b100);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("midrd async clear", {hs(0), bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr}, 37'd0);
        check("midrd rdata0", rdata(0), 32'd0);
        tick();
        check("midrd held", hs(0), 3'b000);
        reset = 1'b1;
        tick();
        check("midrd no done", hs(0), 3'b000);
        $display("txn midread-reset abandoned");
        txn("rd2000 after reset", 0, 1'b0, 32'h2000, 32'd0, 1'b0, init_word(12'h800));

        // Write then read back on port 0.
        wr_before = wr_cycles;
        txn("wr2000", 0, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0, 32'd0);
        check("wr2000 wr_en cycles", 64'(wr_cycles - wr_before), 64'd1);
        txn("rd2000", 0, 1'b0, 32'h2000, 32'd0, 1'b0, 32'hDEADBEEF);

        // First contention: port 0 favoured, port 1 follows right after IDLE.
        drive(0, 1'b1, 1'b0, 32'h2004, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h2008, 32'd0);
        tick();
        check("contA first gnt", {hs(0), hs(1)}, 6'b100_000);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check("contA p0 done", {hs(0), hs(1)}, 6'b010_000);
        check("contA p0 rdata", rdata(0), init_word(12'h801));
        tick();
        tick();
        check("contA second gnt", {hs(0), hs(1)}, 6'b000_100);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check("contA p1 done", hs(1), 3'b010);
        check("contA p1 rdata", rdata(1), init_word(12'h802));
        tick();
        $display("txn contention A done");

        // Second contention: port 1 now favoured.
        drive(0, 1'b1, 1'b1, 32'h2010, 32'h1111_1111);
        drive(1, 1'b1, 1'b1, 32'h2014, 32'h2222_2222);
        tick();
        check("contB first gnt", {hs(0), hs(1)}, 6'b000_100);
        check("contB first addr", bus.mem_addr, 32'h2014);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("contB p1 done", hs(1), 3'b010);
        tick();
        tick();
        check("contB second gnt", {hs(0), hs(1)}, 6'b100_000);
        check("contB second addr", bus.mem_addr, 32'h2010);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("contB p0 done", hs(0), 3'b010);
        tick();
        $display("txn contention B done");

        // Port 0 keeps requesting; port 1 must get in after one port 0 op.
        drive(0, 1'b1, 1'b1, 32'h2018, 32'h3333_3333);
        drive(1, 1'b1, 1'b0, 32'h2014, 32'd0);
        tick();
        check("starve first gnt", {hs(0), hs(1)}, 6'b100_000);
        tick();
        check("starve p0 done", hs(0), 3'b010);
        tick();
        tick();
        check("starve p1 served", {hs(0), hs(1)}, 6'b000_100);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check("starve p1 done", hs(1), 3'b010);
        check("starve p1 rdata", rdata(1), 32'h2222_2222);
        tick();
        tick();
        check("starve p0 again", {hs(0), hs(1)}, 6'b100_000);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("starve p0 done2", hs(0), 3'b010);
        tick();
        $display("txn starvation done");
        txn("rd2018", 0, 1'b0, 32'h2018, 32'd0, 1'b0, 32'h3333_3333);

        // Illegal addresses on port 1.
        txn("ill rd0100", 1, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'd0);
        txn("ill wr2002", 1, 1'b1, 32'h2002, 32'h5555_5555, 1'b1, 32'd0);

        // Region boundaries and full-width compare.
        txn("bnd rd1FFC", 0, 1'b0, 32'h1FFC, 32'd0, 1'b1, 32'd0);
        txn("bnd rd2000", 0, 1'b0, 32'h2000, 32'd0, 1'b0, 32'hDEADBEEF);
        txn("bnd rd3FFC", 0, 1'b0, 32'h3FFC, 32'd0, 1'b0, init_word(12'hFFF));
        txn("bnd rd4000", 0, 1'b0, 32'h4000, 32'd0, 1'b1, 32'd0);
        txn("bnd rd80002000", 0, 1'b0, 32'h8000_2000, 32'd0, 1'b1, 32'd0);

        check("never both enables", 64'(both_cycles), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
